alu_multdiv: RTL and testbench
==============================

# alu_multdiv

Iterative signed 32-bit multiply/divide unit alongside the single-cycle ALU in the execute stage. The ALU's bitwise operations produce results in the same cycle. This block is the multicycle counterpart: it accepts a one-cycle start pulse, iterates one bit per clock, and hands back a result with a one-cycle ready pulse. The execute stage stalls on `busy` and captures `data_result` when `data_resultRDY` is high.

## Interface
Parameters:
- `WIDTH`, default 32: operand/result width. The counter width is derived from it.

Ports:
- `clock`  in  1: single clock, all state on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `ctrl_MULT`  in  1: one-cycle start pulse for a signed multiply.
- `ctrl_DIV`  in  1: one-cycle start pulse for a signed divide.
- `data_operandA`  in  WIDTH: multiplicand or dividend. Sampled only on the start edge.
- `data_operandB`  in  WIDTH: multiplier or divisor. Sampled only on the start edge.
- `data_result`  out  WIDTH: low WIDTH bits of the product, or the quotient. Held until the next completion.
- `data_exception`  out  1: high on overflow or divide-by-zero. Qualified by `data_resultRDY` and held with `data_result`.
- `data_resultRDY`  out  1: one-cycle completion pulse.
- `busy`  out  1: high from the start edge until the completion edge.

## Operation
- States:
  - IDLE
  - RUN: counter 0..WIDTH-1, one iteration per edge.
  - FIN: sign-correct the result, evaluate the exception, write the outputs.
- IDLE with `ctrl_MULT`=1: latch the operands, store their magnitudes and the result sign, go to RUN.
- IDLE with `ctrl_DIV`=1 and `ctrl_MULT`=0: same as multiply. If the divisor is 0, go straight to FIN with the exception flag set.
- IDLE with both starts high in the same cycle: multiply wins and divide is dropped.
- A start pulse outside IDLE is ignored (not queued).
- Multiply: unsigned shift-add on the magnitudes into a 2·WIDTH accumulator, then two's-complement negation if the operand signs differ.
  - Exception when the signed product does not fit in WIDTH bits: the upper WIDTH+1 bits of the signed product are not all equal.
  - `data_result` is the low WIDTH bits even when the exception is set.
- Divide: restoring division on the magnitudes. The quotient truncates toward zero and the quotient sign is A xor B. The remainder is discarded.
  - Divide-by-zero: `data_result`=0, `data_exception`=1.
  - Divide of −2^(WIDTH−1) by −1: `data_result`=0x80000000, `data_exception`=1.
- RUN after iteration WIDTH−1: go to FIN.
- FIN edge: drive `data_result` and `data_exception`, pulse `data_resultRDY`, go to IDLE.
- Reset values: state IDLE, `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0.
- Reset asserted mid-operation aborts immediately. No ready pulse is produced for the aborted operation.

## Timing
- The start is sampled at edge 0.
- `busy` is high after edge 0 and low after the FIN edge.
- Normal multiply or divide: WIDTH RUN edges (1..WIDTH), then the FIN edge at WIDTH+1.
  - `data_resultRDY` is high for exactly the cycle after edge WIDTH+1, which is edge 33 for WIDTH=32.
- Divide-by-zero: the FIN edge is edge 1, so `data_resultRDY` is high after edge 1.
- A new start is accepted in the same cycle that `data_resultRDY` is high, because the block is already in IDLE.
- There is no combinational path from any input to any output.

## Configuration
- `ALU_MULTDIV_DIV_EN` defined: the divider datapath and the divide handling above are compiled in.
- `ALU_MULTDIV_DIV_EN` undefined: no divider logic is built.
  - `ctrl_DIV` behaves like divide-by-zero: FIN at edge 1, `data_result`=0, `data_exception`=1.
  - Multiply behaviour is unchanged.

## Test plan
- Multiply 7 × −3 (0xFFFFFFFD): `busy` 1 through edge 33, then `data_resultRDY` for one cycle with 0xFFFFFFEB and exception 0.
- Multiply 0x00010000 × 0x00010000: result 0x00000000, exception 1, ready after edge 33.
- Divide −17 (0xFFFFFFEF) ÷ 5: result 0xFFFFFFFD, exception 0. Divide 0x80000000 ÷ 0xFFFFFFFF: result 0x80000000, exception 1.
- Divide 42 ÷ 0: ready after edge 1, result 0, exception 1.
- Busy and simultaneous starts:
  - Pulse `ctrl_DIV` at edge 10 of a running multiply: ignored, only the multiply result appears.
  - Pulse `ctrl_MULT` and `ctrl_DIV` together with 6 and 3: result 18.
- Drive `reset` low at edge 15 of a multiply: all outputs 0 immediately, and no ready pulse appears over the next 40 cycles.
  - Release reset and multiply 2 × 3: result 6.
  - Rebuild without `ALU_MULTDIV_DIV_EN`: divide 10 ÷ 2 gives ready after edge 1, result 0, exception 1.

Source files
------------

// File: rtl/alu_multdiv.sv
// Iterative signed multiply/divide: one bit per clock, registered result with a one-cycle ready pulse.
// Define ALU_MULTDIV_DIV_EN to build the restoring divider; otherwise a divide request reports divide-by-zero.
module alu_multdiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  // Handshake: ctrl_MULT/ctrl_DIV are accepted only on an edge where the unit is idle;
  // busy covers start edge to completion edge, data_resultRDY is a single-cycle valid.
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_q, neg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;
`ifdef ALU_MULTDIV_DIV_EN
  logic               is_div_q, is_div_d;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [WIDTH-1:0]   quo_s;
`endif

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_s;
  logic               mul_ovf;

  always_comb begin
    mag_a   = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    mag_b   = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    prod_s  = neg_q ? (~acc_q + 1'b1) : acc_q;
    // Product fits in WIDTH signed bits only if the top WIDTH+1 bits are a pure sign extension.
    mul_ovf = !((&prod_s[2*WIDTH-1:WIDTH-1]) || ~(|prod_s[2*WIDTH-1:WIDTH-1]));
`ifdef ALU_MULTDIV_DIV_EN
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    quo_s     = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
`ifdef ALU_MULTDIV_DIV_EN
    is_div_d = is_div_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (ctrl_MULT) begin
          opnd_d  = mag_a;
          acc_d   = {{WIDTH{1'b0}}, mag_b};
          neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          dz_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef ALU_MULTDIV_DIV_EN
          is_div_d = 1'b0;
`endif
        end else if (ctrl_DIV) begin
`ifdef ALU_MULTDIV_DIV_EN
          opnd_d   = mag_b;
          acc_d    = {{WIDTH{1'b0}}, mag_a};
          neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          is_div_d = 1'b1;
          dz_d     = (data_operandB == '0);
          cnt_d    = '0;
          state_d  = (data_operandB == '0) ? S_FIN : S_RUN;
`else
          dz_d    = 1'b1;
          state_d = S_FIN;
`endif
        end
      end
      S_RUN: begin
`ifdef ALU_MULTDIV_DIV_EN
        if (is_div_q) begin
          // Restoring step: keep the trial subtraction only when it did not borrow.
          if (!div_diff[WIDTH+1]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                    acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
`else
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
`endif
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = S_FIN;
      end
      S_FIN: begin
        rdy_d   = 1'b1;
        state_d = S_IDLE;
        if (dz_q) begin
          result_d = '0;
          exc_d    = 1'b1;
`ifdef ALU_MULTDIV_DIV_EN
        end else if (is_div_q) begin
          // Only MIN / -1 yields a positive quotient with the top magnitude bit set.
          result_d = quo_s;
          exc_d    = !neg_q && acc_q[WIDTH-1];
`endif
        end else begin
          result_d = prod_s[WIDTH-1:0];
          exc_d    = mul_ovf;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
`ifdef ALU_MULTDIV_DIV_EN
      is_div_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
`ifdef ALU_MULTDIV_DIV_EN
      is_div_q <= is_div_d;
`endif
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q != S_IDLE);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_alu_multdiv.sv
// Scoreboard bench for alu_multdiv: a reference model pushes {ready edge, exception, result} per start.
module tb_alu_multdiv;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         ctrl_MULT = 1'b0;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;
  logic [1:0]   dbg_state_o;

  alu_multdiv #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy), .dbg_state_o(dbg_state_o)
  );

  // clock / reset / edge counter
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_count = 0;
  bit prev_rdy = 1'b0;
  logic [48:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] mul_model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] p;
    logic ovf;
    p   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    ovf = !((&p[63:31]) || ~(|p[63:31]));
    return {ovf, p[31:0]};
  endfunction

  function automatic logic [32:0] div_model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef ALU_MULTDIV_DIV_EN
    logic signed [31:0] q;
    if (b == 0) return {1'b1, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    return {1'b0, q};
`else
    return {1'b1, 32'h0};
`endif
  endfunction

  function automatic int div_lat(input logic [W-1:0] b);
`ifdef ALU_MULTDIV_DIV_EN
    return (b == 0) ? 1 : W + 1;
`else
    return 1;
`endif
  endfunction

  // Driver: caller is at a negedge; the start is sampled at the next posedge (edge 0).
  task automatic start_op(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [32:0] r;
    int lat;
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
    if (m) begin r = mul_model(a, b); lat = W + 1; end
    else   begin r = div_model(a, b); lat = div_lat(b); end
    exp_q.push_back({16'(cyc + lat), r});
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clock); n++; end
    check("drain_timeout", exp_q.size(), 0);
    @(negedge clock);
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!data_resultRDY && n < 60) begin @(negedge clock); n++; end
    check("rdy_timeout", data_resultRDY, 1);
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    logic [48:0] e;
    if (prev_rdy) check("rdy_width", data_resultRDY, 0);
    if (data_resultRDY) begin
      rdy_count++;
      if (exp_q.size() == 0) check("rdy_spurious", data_resultRDY, 0);
      else begin
        e = exp_q.pop_front();
        check("result", data_result, e[31:0]);
        check("exception", data_exception, e[32]);
        check("ready_edge", cyc, e[48:33]);
      end
    end
    prev_rdy = data_resultRDY;
  end

  initial begin
    int saved;
    logic [W-1:0] a, b;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_result", data_result, 0);
    check("rst_exc", data_exception, 0);
    check("rst_rdy", data_resultRDY, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state_o, 0);
    reset = 1'b1;
    @(negedge clock);

    // 7 * -3 with busy timing
    start_op(1, 0, 32'd7, 32'hFFFF_FFFD);
    check("busy_start", busy, 1);
    repeat (W) @(posedge clock);
    #1;
    check("busy_edge32", busy, 1);
    check("rdy_edge32", data_resultRDY, 0);
    @(posedge clock); #1;
    check("busy_edge33", busy, 0);
    check("rdy_edge33", data_resultRDY, 1);
    wait_drain();

    start_op(1, 0, 32'h0001_0000, 32'h0001_0000); wait_drain();
    start_op(0, 1, 32'hFFFF_FFEF, 32'd5);         wait_drain();
    start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF); wait_drain();
    start_op(0, 1, 32'd42, 32'd0);                wait_drain();
    start_op(0, 1, 32'd10, 32'd2);                wait_drain();
    start_op(1, 1, 32'd6, 32'd3);                 wait_drain();
    start_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF); wait_drain();

    // divide pulse at edge 10 of a running multiply must be ignored
    start_op(1, 0, 32'd5, 32'd9);
    repeat (9) @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    wait_drain();
    repeat (40) @(negedge clock);

    // back-to-back: new start in the ready cycle
    start_op(1, 0, 32'd2, 32'd3);
    wait_rdy();
    start_op(1, 0, 32'hFFFF_FFFC, 32'd5);
    wait_drain();

    for (int i = 0; i < 8; i++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2000)) - 32'd1000;
      b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
      start_op(i[0], !i[0], a, b);
      wait_drain();
    end

    // asynchronous abort at edge 15
    start_op(1, 0, 32'd123, 32'd456);
    repeat (15) @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    saved = rdy_count;
    #1;
    check("abort_result", data_result, 0);
    check("abort_exc", data_exception, 0);
    check("abort_rdy", data_resultRDY, 0);
    check("abort_busy", busy, 0);
    repeat (40) @(negedge clock);
    check("abort_no_rdy", rdy_count, saved);
    reset = 1'b1;
    @(negedge clock);
    start_op(1, 0, 32'd2, 32'd3);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
